mram_burst_rw: RTL and testbench

Parametrised MRAM burst read/write/verify engine, the next generation of the single-word MRAM_RW controller on the MRAM test board. It runs a host-requested burst of writes, read-verifies, or write-then-readback operations over a contiguous address range. Data is a configurable pattern, optionally inverted and/or address-scrambled. Per-burst cycle latency, bad-bit count, failing-word count and first failing address are reported back to the host.

---
 rtl/mram_burst_rw.sv | 214 +++++++++++++++++++++
 tb/tb_mram_burst_rw.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mram_burst_rw.sv
// MRAM burst write / read-verify / write-readback / delay engine.
// Reports burst latency, mismatched bit count, failing word count and first failing address.
module mram_burst_rw #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 18,
  parameter logic [DATA_W-1:0] PATTERN     = 'h35A9,
  parameter int                WAIT_CYC    = 10,
  parameter int                RECOVER_CYC = 2,
  parameter int                DELAY_CYC   = 200000
) (
  input  logic              CLKM,
  input  logic              RST_N,
  input  logic              start,
  input  logic [1:0]        oper,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       burst_len,
  input  logic              inverse_pattern,
  input  logic              addr_xor,
  output logic              done,
  output logic              busy,
  output logic [31:0]       latency,
  output logic [31:0]       badbits,
  output logic [15:0]       fail_cnt,
  output logic [ADDR_W-1:0] first_fail_addr,
  output logic              e_n,
  output logic              w_n,
  output logic              g_n,
  output logic              ub_n,
  output logic              lb_n,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [DATA_W-1:0] dq,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    IDLE, DECODE, WR_SETUP, WR_PULSE, WR_RECOVER,
    RD_SETUP, RD_WAIT, RD_SAMPLE, DELAY, DONE
  } state_t;

  localparam logic [31:0] WAIT_M1 = 32'(WAIT_CYC - 1);
  localparam logic [31:0] REC_M1  = 32'(RECOVER_CYC - 1);
  localparam logic [31:0] DLY_M1  = 32'(DELAY_CYC - 1);

  state_t              state_q, state_d;
  logic [1:0]          oper_q, oper_d;
  logic                inv_q, inv_d, xor_q, xor_d;
  logic [15:0]         words_q, words_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [31:0]         latency_q, latency_d, badbits_q, badbits_d;
  logic [15:0]         fail_q, fail_d;
  logic [ADDR_W-1:0]   ffa_q, ffa_d;
  logic [4:0]          ctl_q, ctl_d;   // {e_n, w_n, g_n, ub_n, lb_n}
  logic                oe_q, oe_d, done_q, done_d, busy_q, busy_d;

  logic [DATA_W-1:0]   exp_word, diff;
  logic [31:0]         pop;
  logic [32:0]         badsum;
  logic                adv;

  assign exp_word = PATTERN ^ {DATA_W{inv_q}} ^ (xor_q ? DATA_W'(addr_q) : '0);
  assign diff     = rdata_q ^ exp_word;
  assign badsum   = {1'b0, badbits_q} + {1'b0, pop};

  always_comb begin
    pop = '0;
    for (int i = 0; i < DATA_W; i++) pop = pop + 32'(diff[i]);
  end

  always_comb begin
    state_d   = state_q;
    oper_d    = oper_q;
    inv_d     = inv_q;
    xor_d     = xor_q;
    words_d   = words_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    latency_d = latency_q;
    badbits_d = badbits_q;
    fail_d    = fail_q;
    ffa_d     = ffa_q;
    adv       = 1'b0;

    if (state_q != IDLE && state_q != DONE && latency_q != 32'hFFFF_FFFF)
      latency_d = latency_q + 32'd1;

    case (state_q)
      IDLE: if (start) begin
        latency_d = '0;
        badbits_d = '0;
        fail_d    = '0;
        ffa_d     = '0;
        oper_d    = oper;
        inv_d     = inverse_pattern;
        xor_d     = addr_xor;
        addr_d    = base_addr;
        words_d   = (burst_len == 16'd0) ? 16'd0 : burst_len - 16'd1;
        state_d   = DECODE;
      end
      DECODE: begin
        case (oper_q)
          2'd1:    state_d = RD_SETUP;
          2'd3:    begin state_d = DELAY; cnt_d = DLY_M1; end
          default: state_d = WR_SETUP;
        endcase
      end
      WR_SETUP: begin state_d = WR_PULSE; cnt_d = WAIT_M1; end
      WR_PULSE: begin
        if (cnt_q == 32'd0) begin state_d = WR_RECOVER; cnt_d = REC_M1; end
        else cnt_d = cnt_q - 32'd1;
      end
      WR_RECOVER: begin
        if (cnt_q != 32'd0) cnt_d = cnt_q - 32'd1;
        else if (oper_q == 2'd2) state_d = RD_SETUP;
        else adv = 1'b1;
      end
      RD_SETUP: begin state_d = RD_WAIT; cnt_d = WAIT_M1; end
      RD_WAIT: begin
        // Capture while the memory is still enabled; compare happens in RD_SAMPLE.
        if (cnt_q == 32'd0) begin state_d = RD_SAMPLE; rdata_d = dq; end
        else cnt_d = cnt_q - 32'd1;
      end
      RD_SAMPLE: begin
        badbits_d = badsum[32] ? 32'hFFFF_FFFF : badsum[31:0];
        if (diff != '0) begin
          if (fail_q != 16'hFFFF) fail_d = fail_q + 16'd1;
          if (fail_q == 16'd0)    ffa_d  = addr_q;
        end
        adv = 1'b1;
      end
      DELAY: begin
        if (cnt_q == 32'd0) state_d = DONE;
        else cnt_d = cnt_q - 32'd1;
      end
      DONE: if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (adv) begin
      if (words_q != 16'd0) begin
        words_d = words_q - 16'd1;
        addr_d  = addr_q + ADDR_W'(1);
        state_d = (oper_q == 2'd1) ? RD_SETUP : WR_SETUP;
      end else begin
        state_d = DONE;
      end
    end

    // Pin controls are decoded from the next state so the registered pins line up with state_q.
    ctl_d = 5'b11111;
    oe_d  = 1'b0;
    case (state_d)
      WR_SETUP:          begin ctl_d = 5'b01100; oe_d = 1'b1; end
      WR_PULSE:          begin ctl_d = 5'b00100; oe_d = 1'b1; end
      WR_RECOVER:        begin ctl_d = 5'b11111; oe_d = 1'b1; end
      RD_SETUP, RD_WAIT: ctl_d = 5'b01000;
      default:           ctl_d = 5'b11111;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  always_ff @(posedge CLKM or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      oper_q    <= '0;
      inv_q     <= 1'b0;
      xor_q     <= 1'b0;
      words_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      rdata_q   <= '0;
      latency_q <= '0;
      badbits_q <= '0;
      fail_q    <= '0;
      ffa_q     <= '0;
      ctl_q     <= 5'b11111;
      oe_q      <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      oper_q    <= oper_d;
      inv_q     <= inv_d;
      xor_q     <= xor_d;
      words_q   <= words_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rdata_q   <= rdata_d;
      latency_q <= latency_d;
      badbits_q <= badbits_d;
      fail_q    <= fail_d;
      ffa_q     <= ffa_d;
      ctl_q     <= ctl_d;
      oe_q      <= oe_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign dq              = oe_q ? exp_word : 'z;
  assign {e_n, w_n, g_n, ub_n, lb_n} = ctl_q;
  assign addr            = addr_q;
  assign done            = done_q;
  assign busy            = busy_q;
  assign latency         = latency_q;
  assign badbits         = badbits_q;
  assign fail_cnt        = fail_q;
  assign first_fail_addr = ffa_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_mram_burst_rw.sv
// Directed bench for mram_burst_rw with a small MRAM model, write log scoreboard and fault injection on reads.
module tb_mram_burst_rw;
  localparam int DW = 16, AW = 18, WC = 10, RC = 2, DC = 20;

  logic          CLKM, RST_N, start, inverse_pattern, addr_xor;
  logic [1:0]    oper;
  logic [AW-1:0] base_addr;
  logic [15:0]   burst_len;
  logic          done, busy, e_n, w_n, g_n, ub_n, lb_n;
  logic [31:0]   latency, badbits;
  logic [15:0]   fail_cnt;
  logic [AW-1:0] first_fail_addr, addr;
  logic [3:0]    dbg_state;
  wire  [DW-1:0] dq;

  mram_burst_rw #(.DATA_W(DW), .ADDR_W(AW), .PATTERN(16'h35A9), .WAIT_CYC(WC),
                  .RECOVER_CYC(RC), .DELAY_CYC(DC)) dut (
    .CLKM(CLKM), .RST_N(RST_N), .start(start), .oper(oper), .base_addr(base_addr),
    .burst_len(burst_len), .inverse_pattern(inverse_pattern), .addr_xor(addr_xor),
    .done(done), .busy(busy), .latency(latency), .badbits(badbits), .fail_cnt(fail_cnt),
    .first_fail_addr(first_fail_addr), .e_n(e_n), .w_n(w_n), .g_n(g_n), .ub_n(ub_n),
    .lb_n(lb_n), .addr(addr), .dq(dq), .dbg_state(dbg_state));

  // clock / reset
  initial CLKM = 1'b0;
  always #5 CLKM = ~CLKM;

  // MRAM model: word array indexed by the low address byte, optional bit flips on read
  logic [DW-1:0] mem [0:255];
  logic [DW-1:0] mem_rd;
  logic [AW-1:0] fa1, fa2;
  logic [DW-1:0] fm1, fm2;
  logic          w_prev;
  int            bus_viol, ctl_low;
  logic [AW+DW-1:0] wlog[$];
  logic [AW+DW-1:0] exp_q[$];
  int            n_vec, n_err;

  always_comb mem_rd = mem[addr[7:0]] ^ ((addr == fa1) ? fm1 : '0) ^ ((addr == fa2) ? fm2 : '0);
  assign dq = (!e_n && !g_n) ? mem_rd : 'z;

  always @(negedge CLKM) begin
    if (!e_n && !w_n && w_prev) begin
      wlog.push_back({addr, dq});
      mem[addr[7:0]] = dq;
    end
    w_prev = w_n;
    if (!w_n && !g_n) bus_viol++;
    if ({e_n, w_n, g_n, ub_n, lb_n} != 5'h1F) ctl_low++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [AW-1:0] base, input logic [15:0] len,
                        input logic inv, input logic xr);
    logic got, bs;
    got = 1'b0;
    bs  = 1'b0;
    @(negedge CLKM);
    oper = op; base_addr = base; burst_len = len; inverse_pattern = inv; addr_xor = xr;
    start = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLKM);
      if (busy) bs = 1'b1;
      if (done) begin got = 1'b1; break; end
    end
    check("done_reached", 64'(got), 64'd1);
    check("busy_seen", 64'(bs), 64'd1);
  endtask

  task automatic end_op();
    start = 1'b0;
    @(negedge CLKM);
    check("idle_done", 64'(done), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic check_results(input string tag, input logic [31:0] lat, input logic [31:0] bb,
                               input logic [15:0] fc, input logic [AW-1:0] ffa);
    check({tag, "_latency"}, 64'(latency), 64'(lat));
    check({tag, "_badbits"}, 64'(badbits), 64'(bb));
    check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(fc));
    check({tag, "_first_fail"}, 64'(first_fail_addr), 64'(ffa));
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, 64'(wlog.size()), 64'(exp_q.size()));
    while (wlog.size() > 0 && exp_q.size() > 0)
      check({tag, "_wr_word"}, 64'(wlog.pop_front()), 64'(exp_q.pop_front()));
    wlog.delete();
    exp_q.delete();
  endtask

  initial begin
    logic got;
    n_vec = 0; n_err = 0; bus_viol = 0; ctl_low = 0; w_prev = 1'b1;
    fa1 = '1; fa2 = '1; fm1 = '0; fm2 = '0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    RST_N = 1'b0; start = 1'b0; oper = '0; base_addr = '0; burst_len = '0;
    inverse_pattern = 1'b0; addr_xor = 1'b0;
    repeat (3) @(negedge CLKM);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check_results("rst", 32'd0, 32'd0, 16'd0, '0);
    check("rst_ctl", 64'({e_n, w_n, g_n, ub_n, lb_n}), 64'h1F);
    check("rst_addr", 64'(addr), 64'd0);
    RST_N = 1'b1;
    @(negedge CLKM);

    // Reset in the middle of a write pulse
    oper = 2'd0; base_addr = 18'h00020; burst_len = 16'd3; start = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLKM);
      if (!w_n) begin got = 1'b1; break; end
    end
    check("pulse_reached", 64'(got), 64'd1);
    repeat (3) @(negedge CLKM);
    #2 RST_N = 1'b0;
    #1;
    check("midrst_ctl", 64'({e_n, w_n, g_n, ub_n, lb_n}), 64'h1F);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_latency", 64'(latency), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'd0);
    start = 1'b0;
    @(negedge CLKM);
    RST_N = 1'b1;
    wlog.delete();

    // Write burst across the address wrap
    run_op(2'd0, 18'h3FFFE, 16'd4, 1'b0, 1'b0);
    check_results("wr4", 32'd53, 32'd0, 16'd0, '0);
    exp_q.push_back({18'h3FFFE, 16'h35A9});
    exp_q.push_back({18'h3FFFF, 16'h35A9});
    exp_q.push_back({18'h00000, 16'h35A9});
    exp_q.push_back({18'h00001, 16'h35A9});
    check_writes("wr4");
    end_op();

    // Clean read-verify
    run_op(2'd1, 18'h3FFFE, 16'd4, 1'b0, 1'b0);
    check_results("rd_clean", 32'd49, 32'd0, 16'd0, '0);
    check_writes("rd_clean");
    end_op();
    check("hold_after_idle", 64'(latency), 64'd49);

    // Three flipped bits at address 0
    fa1 = 18'h00000; fm1 = 16'h0111;
    run_op(2'd1, 18'h3FFFE, 16'd4, 1'b0, 1'b0);
    check_results("rd_flip3", 32'd49, 32'd3, 16'd1, 18'h00000);
    end_op();

    // Two failing words; first failure is the earlier address
    fa1 = 18'h3FFFF; fm1 = 16'h8001; fa2 = 18'h00001; fm2 = 16'h00FF;
    run_op(2'd1, 18'h3FFFE, 16'd4, 1'b0, 1'b0);
    check_results("rd_flip2w", 32'd49, 32'd10, 16'd2, 18'h3FFFF);
    end_op();
    fa1 = '1; fa2 = '1; fm1 = '0; fm2 = '0;

    // Write-then-readback, inverted and address-scrambled
    run_op(2'd2, 18'h00010, 16'd2, 1'b1, 1'b1);
    check_results("wrb", 32'd51, 32'd0, 16'd0, '0);
    exp_q.push_back({18'h00010, 16'hCA46});
    exp_q.push_back({18'h00011, 16'hCA47});
    check_writes("wrb");
    end_op();

    // burst_len of zero behaves as one word
    run_op(2'd0, 18'h00005, 16'd0, 1'b0, 1'b0);
    check_results("len0", 32'd14, 32'd0, 16'd0, '0);
    exp_q.push_back({18'h00005, 16'h35A9});
    check_writes("len0");
    end_op();

    // Delay with start held after completion
    ctl_low = 0;
    run_op(2'd3, 18'h00000, 16'd1, 1'b0, 1'b0);
    check("dly_latency", 64'(latency), 64'd21);
    repeat (5) @(negedge CLKM);
    check("dly_done_held", 64'(done), 64'd1);
    check("dly_pins_idle", 64'(ctl_low), 64'd0);
    check_writes("dly");
    end_op();
    check("dly_state_idle", 64'(dbg_state), 64'd0);
    check("dly_latency_kept", 64'(latency), 64'd21);

    check("bus_conflict", 64'(bus_viol), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
